// File: rtl/board_port_arbiter.sv
// Single-port board RAM arbiter: display first, then the bulk clear sequencer,
// then round-robin between game port A (writer) and game port B (reader).
module board_port_arbiter #(
  parameter int W      = 10,
  parameter int H      = 20,
  parameter int KIND_W = 4,
  parameter int AW     = $clog2(W*H)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              disp_req,
  input  logic [4:0]        disp_x,
  input  logic [4:0]        disp_y,
  output logic [KIND_W-1:0] disp_kind,
  input  logic              a_req,
  input  logic              a_we,
  input  logic [4:0]        a_x,
  input  logic [4:0]        a_y,
  input  logic [KIND_W-1:0] a_wdata,
  output logic              a_gnt,
  output logic              a_rvalid,
  output logic [KIND_W-1:0] a_rdata,
  input  logic              b_req,
  input  logic              b_we,
  input  logic [4:0]        b_x,
  input  logic [4:0]        b_y,
  input  logic [KIND_W-1:0] b_wdata,
  output logic              b_gnt,
  output logic              b_rvalid,
  output logic [KIND_W-1:0] b_rdata,
  input  logic              clear_start,
  output logic              clear_busy,
  output logic              clear_done,
  output logic [AW-1:0]     ram_addr,
  output logic              ram_we,
  output logic [KIND_W-1:0] ram_wdata,
  input  logic [KIND_W-1:0] ram_rdata
);

  typedef enum logic {S_IDLE, S_RUN} clr_state_t;

  clr_state_t          r_state;
  logic [AW-1:0]       r_clr_cnt;
  logic                r_clr_done;
  logic                r_last_b;
  logic                r_d_v, r_d_oor;
  logic                r_a_rd, r_a_oor, r_b_rd, r_b_oor;
  logic                r_a_rvalid, r_b_rvalid;
  logic [KIND_W-1:0]   r_disp_kind, r_a_rdata, r_b_rdata;

  logic w_disp_in, w_disp_hit, w_busy, w_free;
  logic w_a_in, w_b_in, w_a_gnt, w_b_gnt;

  function automatic logic f_in(input logic [4:0] x, input logic [4:0] y);
    return (32'(x) < 32'(W)) && (32'(y) < 32'(H));
  endfunction

  // Truncation is harmless: out-of-range addresses never write or return data.
  function automatic logic [AW-1:0] f_addr(input logic [4:0] x, input logic [4:0] y);
    return AW'(y) * AW'(W) + AW'(x);
  endfunction

  assign w_disp_in  = f_in(disp_x, disp_y);
  assign w_disp_hit = disp_req && w_disp_in;
  assign w_busy     = (r_state == S_RUN);
  assign w_free     = !reset && !w_disp_hit && !w_busy;
  assign w_a_in     = f_in(a_x, a_y);
  assign w_b_in     = f_in(b_x, b_y);
  // r_last_b=1 means B was granted last, so A is favoured on a tie.
  assign w_a_gnt    = w_free && a_req && (!b_req || r_last_b);
  assign w_b_gnt    = w_free && b_req && (!a_req || !r_last_b);

  assign a_gnt      = w_a_gnt;
  assign b_gnt      = w_b_gnt;
  assign clear_busy = w_busy;
  assign clear_done = r_clr_done;
  assign disp_kind  = r_disp_kind;
  assign a_rvalid   = r_a_rvalid;
  assign a_rdata    = r_a_rdata;
  assign b_rvalid   = r_b_rvalid;
  assign b_rdata    = r_b_rdata;

  always_comb begin
    ram_addr  = '0;
    ram_we    = 1'b0;
    ram_wdata = '0;
    if (w_disp_hit) begin
      ram_addr = f_addr(disp_x, disp_y);
    end else if (w_busy) begin
      ram_addr = r_clr_cnt;
      ram_we   = 1'b1;
    end else if (w_a_gnt) begin
      ram_addr  = f_addr(a_x, a_y);
      ram_we    = a_we && w_a_in;
      ram_wdata = a_wdata;
    end else if (w_b_gnt) begin
      ram_addr  = f_addr(b_x, b_y);
      ram_we    = b_we && w_b_in;
      ram_wdata = b_wdata;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_clr_cnt   <= '0;
      r_clr_done  <= 1'b0;
      r_last_b    <= 1'b1;
      r_d_v       <= 1'b0;
      r_d_oor     <= 1'b0;
      r_a_rd      <= 1'b0;
      r_a_oor     <= 1'b0;
      r_b_rd      <= 1'b0;
      r_b_oor     <= 1'b0;
      r_a_rvalid  <= 1'b0;
      r_b_rvalid  <= 1'b0;
      r_disp_kind <= '0;
      r_a_rdata   <= '0;
      r_b_rdata   <= '0;
    end else begin
      r_d_v   <= w_disp_hit;
      r_d_oor <= disp_req && !w_disp_in;
      if (r_d_v)        r_disp_kind <= ram_rdata;
      else if (r_d_oor) r_disp_kind <= '0;

      r_a_rd     <= w_a_gnt && !a_we;
      r_a_oor    <= !w_a_in;
      r_b_rd     <= w_b_gnt && !b_we;
      r_b_oor    <= !w_b_in;
      r_a_rvalid <= r_a_rd;
      r_b_rvalid <= r_b_rd;
      if (r_a_rd) r_a_rdata <= r_a_oor ? '0 : ram_rdata;
      if (r_b_rd) r_b_rdata <= r_b_oor ? '0 : ram_rdata;

      if (w_a_gnt)      r_last_b <= 1'b0;
      else if (w_b_gnt) r_last_b <= 1'b1;

      r_clr_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (clear_start) begin
            r_state   <= S_RUN;
            r_clr_cnt <= '0;
          end
        end
        S_RUN: begin
          // A display access steals the cycle; the counter simply waits.
          if (!w_disp_hit) begin
            if (r_clr_cnt == AW'(W*H-1)) begin
              r_state    <= S_IDLE;
              r_clr_done <= 1'b1;
            end else begin
              r_clr_cnt <= r_clr_cnt + 1'b1;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_board_port_arbiter.sv
// Directed bench for board_port_arbiter: behavioural board RAM, per-stream
// expected queues drained by monitors, and hand-computed expectations.
module tb_board_port_arbiter;

  logic       clk = 1'b0;
  logic       reset;
  logic       disp_req;
  logic [4:0] disp_x, disp_y;
  logic [3:0] disp_kind;
  logic       a_req, a_we, a_gnt, a_rvalid;
  logic [4:0] a_x, a_y;
  logic [3:0] a_wdata, a_rdata;
  logic       b_req, b_we, b_gnt, b_rvalid;
  logic [4:0] b_x, b_y;
  logic [3:0] b_wdata, b_rdata;
  logic       clear_start, clear_busy, clear_done;
  logic [7:0] ram_addr;
  logic       ram_we;
  logic [3:0] ram_wdata;
  logic [3:0] ram_rdata = 4'h0;
  logic [3:0] mem [0:255] = '{default: 4'hF};

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;
  logic dv1 = 1'b0, dv2 = 1'b0;

  logic [3:0] d_exp_q[$];
  logic [3:0] a_exp_q[$];
  logic [3:0] b_exp_q[$];
  int         a_cyc_q[$];
  int         b_cyc_q[$];

  board_port_arbiter dut (
    .clk(clk), .reset(reset),
    .disp_req(disp_req), .disp_x(disp_x), .disp_y(disp_y), .disp_kind(disp_kind),
    .a_req(a_req), .a_we(a_we), .a_x(a_x), .a_y(a_y), .a_wdata(a_wdata),
    .a_gnt(a_gnt), .a_rvalid(a_rvalid), .a_rdata(a_rdata),
    .b_req(b_req), .b_we(b_we), .b_x(b_x), .b_y(b_y), .b_wdata(b_wdata),
    .b_gnt(b_gnt), .b_rvalid(b_rvalid), .b_rdata(b_rdata),
    .clear_start(clear_start), .clear_busy(clear_busy), .clear_done(clear_done),
    .ram_addr(ram_addr), .ram_we(ram_we), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
  );

  // clock / reset / environment
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (ram_we) mem[ram_addr] <= ram_wdata;
    ram_rdata <= mem[ram_addr];
    cyc <= cyc + 1;
    dv1 <= disp_req;
    dv2 <= dv1;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: act=timeout req=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: act=%0h req=%0h (cyc %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // monitors
  always @(negedge clk) begin
    if (dv2) begin
      if (d_exp_q.size() == 0) check("disp_spurious", 1, 0);
      else check("disp_kind", {28'd0, disp_kind}, {28'd0, d_exp_q.pop_front()});
    end
    if (a_rvalid) begin
      if (a_exp_q.size() == 0) check("a_rvalid_spurious", 1, 0);
      else begin
        check("a_rdata", {28'd0, a_rdata}, {28'd0, a_exp_q.pop_front()});
        check("a_rvalid_cycle", cyc, a_cyc_q.pop_front());
      end
    end
    if (b_rvalid) begin
      if (b_exp_q.size() == 0) check("b_rvalid_spurious", 1, 0);
      else begin
        check("b_rdata", {28'd0, b_rdata}, {28'd0, b_exp_q.pop_front()});
        check("b_rvalid_cycle", cyc, b_cyc_q.pop_front());
      end
    end
  end

  // driver tasks
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic game_op(input bit pb, input bit we, input logic [4:0] x, input logic [4:0] y,
                         input logic [3:0] wd, input logic [3:0] er);
    bit got;
    bit in_r;
    in_r = (x < 5'd10) && (y < 5'd20);
    got  = 1'b0;
    if (pb) begin b_req = 1; b_we = we; b_x = x; b_y = y; b_wdata = wd; end
    else    begin a_req = 1; a_we = we; a_x = x; a_y = y; a_wdata = wd; end
    for (int i = 0; i < 8 && !got; i++) begin
      @(negedge clk);
      if (pb ? b_gnt : a_gnt) begin
        got = 1'b1;
        check(we ? "wr_ram_we" : "rd_ram_we", {31'd0, ram_we}, {31'd0, we & in_r});
        if (we && in_r) begin
          check("wr_addr", {24'd0, ram_addr}, int'(y) * 10 + int'(x));
          check("wr_data", {28'd0, ram_wdata}, {28'd0, wd});
        end
        if (!we) begin
          if (pb) begin b_exp_q.push_back(er); b_cyc_q.push_back(cyc + 2); end
          else    begin a_exp_q.push_back(er); a_cyc_q.push_back(cyc + 2); end
        end
      end
      tick();
    end
    check("gnt_wait", {31'd0, got}, 1);
    if (pb) b_req = 0; else a_req = 0;
  endtask

  task automatic run_clear_to_end(input string tag, input bit from_start);
    int busy_cnt, bad, exp_addr, done_cnt;
    bit fell;
    busy_cnt = 0; bad = 0; exp_addr = 0; done_cnt = 0; fell = 0;
    for (int i = 0; i < 260 && !fell; i++) begin
      @(negedge clk);
      if (clear_done) done_cnt++;
      if (clear_busy) begin
        busy_cnt++;
        if (a_gnt || b_gnt) bad++;
        if (!ram_we || ram_addr != 8'(exp_addr) || ram_wdata != 4'h0) bad++;
        exp_addr++;
      end else begin
        fell = 1;
        check({tag, "_done_at_fall"}, {31'd0, clear_done}, 1);
        if (from_start) begin
          check("gnt_at_busy_fall", {31'd0, a_gnt}, 1);
          check("held_write_addr", {24'd0, ram_addr}, 11);
        end
      end
      tick();
    end
    a_req = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (clear_done) done_cnt++;
      tick();
    end
    check({tag, "_fell"}, {31'd0, fell}, 1);
    check({tag, "_busy_cycles"}, busy_cnt, 200);
    check({tag, "_bad_cycles"}, bad, 0);
    check({tag, "_done_pulses"}, done_cnt, 1);
  endtask

  initial begin
    logic [3:0] pat_a;
    int nw, done_seen;
    reset = 1; disp_req = 0; disp_x = 0; disp_y = 0;
    a_req = 1; a_we = 1; a_x = 0; a_y = 0; a_wdata = 4'h3;
    b_req = 0; b_we = 0; b_x = 0; b_y = 0; b_wdata = 0;
    clear_start = 0;

    // reset state
    @(negedge clk);
    check("rst_disp_kind", {28'd0, disp_kind}, 0);
    check("rst_a_rvalid", {31'd0, a_rvalid}, 0);
    check("rst_b_rvalid", {31'd0, b_rvalid}, 0);
    check("rst_a_rdata", {28'd0, a_rdata}, 0);
    check("rst_b_rdata", {28'd0, b_rdata}, 0);
    check("rst_clear_busy", {31'd0, clear_busy}, 0);
    check("rst_clear_done", {31'd0, clear_done}, 0);
    check("rst_a_gnt", {31'd0, a_gnt}, 0);
    check("rst_ram_we", {31'd0, ram_we}, 0);
    tick();
    a_req = 0;
    tick();
    reset = 0;
    idle(2);

    // A writes (3,5)=7, B reads it back
    game_op(0, 1, 5'd3, 5'd5, 4'h7, 4'h0);
    game_op(1, 0, 5'd3, 5'd5, 4'h0, 4'h7);
    idle(3);

    // display holds the port; the write at the same cell stalls
    disp_req = 1; disp_x = 3; disp_y = 5;
    a_req = 1; a_we = 1; a_x = 3; a_y = 5; a_wdata = 4'h2;
    for (int i = 0; i < 3; i++) begin
      d_exp_q.push_back(4'h7);
      @(negedge clk);
      check("stall_a_gnt", {31'd0, a_gnt}, 0);
      check("stall_ram_we", {31'd0, ram_we}, 0);
      tick();
    end
    disp_req = 0;
    @(negedge clk);
    check("unstall_a_gnt", {31'd0, a_gnt}, 1);
    check("unstall_ram_we", {31'd0, ram_we}, 1);
    check("unstall_addr", {24'd0, ram_addr}, 53);
    tick();
    a_req = 0;
    disp_req = 1;
    d_exp_q.push_back(4'h2);
    tick();
    disp_req = 0;
    idle(4);

    // out-of-range display and game accesses
    disp_req = 1; disp_x = 10; disp_y = 0;
    d_exp_q.push_back(4'h0);
    a_req = 1; a_we = 0; a_x = 0; a_y = 20;
    @(negedge clk);
    check("oor_a_gnt", {31'd0, a_gnt}, 1);
    check("oor_ram_we", {31'd0, ram_we}, 0);
    a_exp_q.push_back(4'h0); a_cyc_q.push_back(cyc + 2);
    tick();
    disp_req = 0; a_req = 0;
    game_op(1, 1, 5'd0, 5'd20, 4'h5, 4'h0);
    idle(4);

    // reset while a read is in flight: its rvalid must never appear
    a_req = 1; a_we = 0; a_x = 3; a_y = 5;
    @(negedge clk);
    check("flush_a_gnt", {31'd0, a_gnt}, 1);
    tick();
    a_req = 0; reset = 1;
    @(negedge clk);
    check("flush_a_rvalid", {31'd0, a_rvalid}, 0);
    tick();
    reset = 0;
    idle(3);

    // round robin after reset: A, B, A, B
    pat_a = 4'b0101;
    a_req = 1; a_we = 0; a_x = 3; a_y = 5;
    b_req = 1; b_we = 0; b_x = 0; b_y = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("rr_a_gnt", {31'd0, a_gnt}, {31'd0, pat_a[i]});
      check("rr_b_gnt", {31'd0, b_gnt}, {31'd0, ~pat_a[i]});
      if (a_gnt) begin a_exp_q.push_back(4'h2); a_cyc_q.push_back(cyc + 2); end
      if (b_gnt) begin b_exp_q.push_back(4'hF); b_cyc_q.push_back(cyc + 2); end
      tick();
    end
    a_req = 0; b_req = 0;
    idle(4);

    // full clear with a game write waiting behind it
    clear_start = 1;
    @(negedge clk);
    check("clr_busy_start_cycle", {31'd0, clear_busy}, 0);
    tick();
    clear_start = 0;
    a_req = 1; a_we = 1; a_x = 1; a_y = 1; a_wdata = 4'h9;
    run_clear_to_end("clr", 1);
    game_op(1, 0, 5'd1, 5'd1, 4'h0, 4'h9);
    game_op(0, 0, 5'd3, 5'd5, 4'h0, 4'h0);
    game_op(0, 0, 5'd9, 5'd19, 4'h0, 4'h0);
    idle(3);

    // reset at counter 100 aborts silently; the next clear restarts at 0
    clear_start = 1;
    tick();
    clear_start = 0;
    nw = 0;
    for (int i = 0; i < 150 && nw < 100; i++) begin
      @(negedge clk);
      if (clear_busy && ram_we) nw++;
      tick();
    end
    check("abort_writes_before", nw, 100);
    check("abort_cnt_100", {24'd0, ram_addr}, 100);
    reset = 1;
    done_seen = 0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check("abort_busy", {31'd0, clear_busy}, 0);
      check("abort_ram_we", {31'd0, ram_we}, 0);
      if (clear_done) done_seen++;
      tick();
    end
    reset = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (clear_done) done_seen++;
      tick();
    end
    check("abort_no_done", done_seen, 0);
    clear_start = 1;
    tick();
    clear_start = 0;
    run_clear_to_end("reclr", 0);

    // final report
    idle(4);
    check("d_q_empty", d_exp_q.size(), 0);
    check("a_q_empty", a_exp_q.size(), 0);
    check("b_q_empty", b_exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
